// File: rtl/ram_controller_ex_pattern_seq_pkg.sv
// Shared constants for the RAM controller example pattern sequencer:
// FSM encoding, LFSR width/step and the error-count ceiling.
package ram_controller_ex_pattern_seq_pkg;

  localparam int LFSR_W = 8;
  localparam logic [7:0] ERR_SAT = 8'd255;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_INIT    = 3'd1;
  localparam state_t ST_WRITE   = 3'd2;
  localparam state_t ST_RD_LOAD = 3'd3;
  localparam state_t ST_READ    = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  // Galois step, polynomial x^8 + x^4 + x^3 + x^2 + 1
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], 1'b0} ^ (v[LFSR_W-1] ? 8'h1D : 8'h00);
  endfunction

endpackage

// File: rtl/ram_controller_ex_pattern_seq_if.sv
// Local request/response bus between the pattern sequencer (master)
// and the RAM controller (slave).
interface ram_controller_ex_pattern_seq_if #(
  parameter int ADDR_W = 8
);
  import ram_controller_ex_pattern_seq_pkg::*;

  logic                local_ready;
  logic                local_write_req;
  logic                local_read_req;
  logic [ADDR_W-1:0]   local_addr;
  logic [LFSR_W-1:0]   local_wdata;
  logic [LFSR_W-1:0]   local_rdata;
  logic                local_rdata_valid;

  modport master (
    input  local_ready, local_rdata, local_rdata_valid,
    output local_write_req, local_read_req, local_addr, local_wdata
  );

  modport slave (
    output local_ready, local_rdata, local_rdata_valid,
    input  local_write_req, local_read_req, local_addr, local_wdata
  );

endinterface

// File: rtl/ram_controller_ex_lfsr8.sv
// 8-bit pattern LFSR with hold (pause/enable) and parallel load.
module ram_controller_ex_lfsr8
  import ram_controller_ex_pattern_seq_pkg::*;
#(
  parameter int SEED = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              pause,
  input  logic              load,
  input  logic [LFSR_W-1:0] ldata,
  output logic [LFSR_W-1:0] data
);

  localparam logic [LFSR_W-1:0] SEED_V = LFSR_W'(SEED);

  logic [LFSR_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = ldata;
    end else if (enable && !pause) begin
      data_d = lfsr_next(data_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= SEED_V;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/ram_controller_ex_pattern_seq.sv
// Pattern sequencer: writes an LFSR pattern over a window, reads it back,
// compares against a regenerated copy and keeps sticky pass/fail status.
module ram_controller_ex_pattern_seq
  import ram_controller_ex_pattern_seq_pkg::*;
#(
  parameter int SEED       = 32,
  parameter int ADDR_W     = 8,
  parameter int NUM_WORDS  = 16,
  parameter int NUM_PASSES = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             loop_en,
  ram_controller_ex_pattern_seq_if.master  bus,
  output logic                             busy,
  output logic                             test_complete,
  output logic                             pnf,
  output logic [7:0]                       err_count
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int PC_W  = $clog2(NUM_PASSES) + 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  WORDS     = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0]  LAST_RCV  = CNT_W'(NUM_WORDS - 1);
  localparam logic [PC_W-1:0]   LAST_PASS = PC_W'(NUM_PASSES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_SAT) ? v : v + 8'd1;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]    rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]    rcv_cnt_q, rcv_cnt_d;
  logic [PC_W-1:0]     pass_cnt_q, pass_cnt_d;
  logic [LFSR_W-1:0]   pass_seed_q, pass_seed_d;
  logic                pnf_q, pnf_d;
  logic [7:0]          err_count_q, err_count_d;

  logic [LFSR_W-1:0]   gen_data, chk_data;
  logic                lfsr_en, write_req, read_req;
  logic                wr_acc, rd_acc, rx, mismatch;

  always_comb begin
    lfsr_en   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    write_req = (state_q == ST_WRITE);
    read_req  = (state_q == ST_READ) && (rd_addr_q < WORDS);
    wr_acc    = write_req && bus.local_ready;
    rd_acc    = read_req && bus.local_ready;
    // Valids outside READ are strays from a previous context and are dropped.
    rx        = (state_q == ST_READ) && bus.local_rdata_valid;
    mismatch  = rx && (bus.local_rdata != chk_data);
  end

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    rcv_cnt_d   = rcv_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    pass_seed_d = pass_seed_q;
    pnf_d       = pnf_q;
    err_count_d = err_count_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pnf_d       = 1'b1;
          err_count_d = 8'd0;
          pass_cnt_d  = '0;
          state_d     = ST_INIT;
        end
      end
      ST_INIT: begin
        pass_seed_d = gen_data;
        wr_addr_d   = '0;
        state_d     = ST_WRITE;
      end
      ST_WRITE: begin
        if (wr_acc) begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          if (wr_addr_q == LAST_ADDR) state_d = ST_RD_LOAD;
        end
      end
      ST_RD_LOAD: begin
        rd_addr_d = '0;
        rcv_cnt_d = '0;
        state_d   = ST_READ;
      end
      ST_READ: begin
        if (rd_acc) rd_addr_d = rd_addr_q + CNT_W'(1);
        if (rx) begin
          rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
          if (mismatch) begin
            pnf_d       = 1'b0;
            err_count_d = sat_inc(err_count_q);
          end
          if (rcv_cnt_q == LAST_RCV) begin
            if (!loop_en && (pass_cnt_q == LAST_PASS)) begin
              state_d = ST_DONE;
            end else begin
              pass_cnt_d = pass_cnt_q + PC_W'(1);
              state_d    = ST_INIT;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      rcv_cnt_q   <= '0;
      pass_cnt_q  <= '0;
      pass_seed_q <= '0;
      pnf_q       <= 1'b1;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      rcv_cnt_q   <= rcv_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      pass_seed_q <= pass_seed_d;
      pnf_q       <= pnf_d;
      err_count_q <= err_count_d;
    end
  end

  // Generator advances once per accepted write; checker once per received word.
  ram_controller_ex_lfsr8 #(.SEED(SEED)) u_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (lfsr_en),
    .pause   (!wr_acc),
    .load    (1'b0),
    .ldata   ('0),
    .data    (gen_data)
  );

  ram_controller_ex_lfsr8 #(.SEED(SEED)) u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (lfsr_en),
    .pause   (!rx),
    .load    (state_q == ST_RD_LOAD),
    .ldata   (pass_seed_q),
    .data    (chk_data)
  );

  assign bus.local_write_req = write_req;
  assign bus.local_read_req  = read_req;
  assign bus.local_addr      = write_req ? wr_addr_q :
                               read_req  ? rd_addr_q[ADDR_W-1:0] : '0;
  assign bus.local_wdata     = gen_data;

  assign busy          = lfsr_en;
  assign test_complete = (state_q == ST_DONE);
  assign pnf           = pnf_q;
  assign err_count     = err_count_q;

endmodule

// File: doc/ram_controller_ex_pattern_seq.md
Name: ram_controller_ex_pattern_seq

Overview:
Sequencer for the RAM controller example driver. It writes an LFSR pseudo-random pattern over a window of addresses, reads the window back and compares each word against a regenerated copy of the pattern. It runs a fixed number of passes or loops continuously, and reports a sticky pass/fail flag and an error count. It sits between the driver top level and the controller local interface, and owns two ram_controller_ex_lfsr8 instances: a generator and a checker.

Parameters:
SEED, 32, initial LFSR value (low 8 bits used)
ADDR_W, 8, local_addr width
NUM_WORDS, 16, words per pass; 1..2**ADDR_W
NUM_PASSES, 2, passes per run when loop_en=0; >=1

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
loop_en  in  1  1 = repeat passes until reset; sampled at the end of each pass
local_ready  in  1  controller accepts the request this cycle
local_write_req  out  1  write request
local_read_req  out  1  read request
local_addr  out  ADDR_W  request address
local_wdata  out  8  write data
local_rdata  in  8  read data
local_rdata_valid  in  1  local_rdata valid this cycle
busy  out  1  high in any state other than IDLE/DONE
test_complete  out  1  high in DONE
pnf  out  1  pass-not-fail; sticky low on a mismatch
err_count  out  8  mismatch count, saturates at 255

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, reset_n.
- Reset values: FSM=IDLE; all requests 0; local_addr 0; busy 0; test_complete 0; pnf 1; err_count 0; pass_cnt 0; both LFSRs at SEED.
- FSM states: IDLE, INIT, WRITE, RD_LOAD, READ, DONE.
- IDLE or DONE, start=1: clear pnf to 1 and err_count to 0; clear pass_cnt; go to INIT. start is ignored in all other states.
- INIT (1 cycle): pass_seed <= gen.data; wr_addr <= 0; go to WRITE.
- WRITE:
  - local_write_req=1, local_addr=wr_addr, local_wdata=gen.data (combinational from the LFSR register).
  - A write is accepted when local_ready=1; then wr_addr increments.
  - gen.pause = !(local_write_req & local_ready), so the generator advances exactly once per accepted write.
  - Accept at wr_addr=NUM_WORDS-1: go to RD_LOAD.
- RD_LOAD (1 cycle): chk.load=1, chk.ldata=pass_seed; rd_addr <= 0; rcv_cnt <= 0.
- READ:
  - Issue: local_read_req=1 while rd_addr<NUM_WORDS; local_addr=rd_addr; rd_addr increments on local_ready.
  - Deassert local_read_req once all NUM_WORDS reads are issued.
  - Outstanding reads are unlimited.
  - Receive: on each local_rdata_valid, compare local_rdata with chk.data. On mismatch: pnf<=0, err_count<=sat(err_count+1).
  - chk.pause = !local_rdata_valid. rcv_cnt increments on each valid.
  - Valid that brings rcv_cnt to NUM_WORDS: if loop_en=0 and pass_cnt=NUM_PASSES-1, go to DONE; otherwise pass_cnt++ and go to INIT.
  - Issue and receive may occur in the same cycle.
- Generator continuity: gen.enable=1 in every state except IDLE/DONE, and gen.pause=1 outside accepted writes. Each pass therefore continues the pattern sequence and pass_seed differs per pass.
- chk.enable follows the same rule as gen.enable.
- Stray local_rdata_valid in any state other than READ: ignored. No compare, no LFSR advance.
- local_addr=0 whenever no request is asserted.
- err_count saturates: it holds at 255 and pnf stays 0.
- pass_cnt width is clog2(NUM_PASSES)+1; it wraps freely when loop_en=1.
- Reset mid-run: async return to reset values. Outstanding reads are dropped; the controller is reset by the same reset_n.

Decomposition:
- Shared package: state encoding enum, LFSR width constant (8), err_count saturation constant (255).
- Sub-module: ram_controller_ex_lfsr8, instantiated twice (gen, chk), parameter seed=SEED. No other sub-modules.

Test Plan:
- Basic pass, SEED=32, NUM_WORDS=4, local_ready always 1, memory model echoes data: wdata at addr 0..3 = 0x20, 0x40, 0x80, 0x1D. Readback gives pnf=1, err_count=0. test_complete rises after pass 2; the pass-2 first word is the value following 0x1D.
- Backpressure: drop local_ready for 3 cycles mid-WRITE. local_wdata and local_addr are held stable, no address is skipped, and the written sequence is identical to the basic case.
- Error injection: memory model corrupts addr 2 (XOR 0x01) → pnf=0 from that valid onward, err_count=1 per pass, so 2 at DONE.
- Saturation: NUM_WORDS=256, all reads corrupted, loop_en=1 → err_count stops at 255 with no wrap; pnf=0.
- Read latency: rdata_valid returns 5 cycles after each read, with bursts of back-to-back valids → compare stays aligned. A stray valid in IDLE changes nothing.
- Async reset asserted mid-READ, then start → outputs at reset values immediately; the new run begins at addr 0 with wdata=0x20.
